idu_stage: RTL and testbench

IDU_STAGE -- requirements
Module: idu_stage

---
 rtl/idu_stage.sv | 150 +++++++++++++++
 tb/tb_idu_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// Decode stage: decodes 32-bit instruction words into fields and an immediate, then queues the
// decoded entries in a small circular FIFO toward the execute side.
module idu_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      inst_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [2:0] TyR   = 3'd0;
  localparam logic [2:0] TyI   = 3'd1;
  localparam logic [2:0] TyS   = 3'd2;
  localparam logic [2:0] TyB   = 3'd3;
  localparam logic [2:0] TyU   = 3'd4;
  localparam logic [2:0] TyJ   = 3'd5;
  localparam logic [2:0] TyR4  = 3'd6;
  localparam logic [2:0] TyInv = 3'd7;

  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [31:0]     inst_q [DEPTH];
  logic [2:0]      type_q [DEPTH];
  logic [XLEN-1:0] imm_q  [DEPTH];
  logic [DEPTH-1:0] ill_q;

  logic [2:0]      dec_type;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic            accept, consume;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    dec_type = TyInv;
    case (in_inst[6:0])
      7'h03, 7'h07, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: dec_type = TyI;
      7'h23, 7'h27:                                    dec_type = TyS;
      7'h2F, 7'h33, 7'h3B, 7'h53:                      dec_type = TyR;
      7'h17, 7'h37:                                    dec_type = TyU;
      7'h43, 7'h47, 7'h4B, 7'h4F:                      dec_type = TyR4;
      7'h63:                                           dec_type = TyB;
      7'h6F:                                           dec_type = TyJ;
      default:                                         dec_type = TyInv;
    endcase
    if (in_inst[1:0] != 2'b11) dec_type = TyInv;
    dec_ill = (dec_type == TyInv);

    // Every immediate fits in 32 bits; widen once with a single sign extension.
    dec_imm32 = '0;
    case (dec_type)
      TyI: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      TyS: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      TyB: dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      TyU: dec_imm32 = {in_inst[31:12], 12'b0};
      TyJ: dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      default: dec_imm32 = '0;
    endcase
    dec_imm = XLEN'($signed(dec_imm32));
  end

  assign out_valid = (count_q != '0);
  assign in_ready  = !rst && (count_q < CW'(DEPTH));
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ill_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        type_q[i] <= '0;
        imm_q[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        pc_q[wr_ptr_q]   <= in_pc;
        inst_q[wr_ptr_q] <= in_inst;
        type_q[wr_ptr_q] <= dec_type;
        imm_q[wr_ptr_q]  <= dec_imm;
        ill_q[wr_ptr_q]  <= dec_ill;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (consume) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (accept && !consume) begin
        count_q <= count_q + CW'(1);
      end else if (!accept && consume) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Stale entries stay in the array after a pop, so data is gated to zero when empty.
  always_comb begin
    out_pc    = '0;
    out_inst  = '0;
    inst_type = '0;
    imm       = '0;
    illegal   = 1'b0;
    if (out_valid) begin
      out_pc    = pc_q[rd_ptr_q];
      out_inst  = inst_q[rd_ptr_q];
      inst_type = type_q[rd_ptr_q];
      imm       = imm_q[rd_ptr_q];
      illegal   = ill_q[rd_ptr_q];
    end
    opcode = out_inst[6:0];
    rd     = out_inst[11:7];
    funct3 = out_inst[14:12];
    rs1    = out_inst[19:15];
    rs2    = out_inst[24:20];
    funct7 = out_inst[31:25];
  end

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: a queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic; a 32-bit instance runs alongside.
module tb_idu_stage;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        in_ready, out_valid, illegal;
  logic [63:0] out_pc, imm;
  logic [31:0] out_inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3, inst_type;
  logic [4:0]  rs1, rs2, rd;

  logic        in_ready_n, out_valid_n, illegal_n;
  logic [31:0] out_pc_n, imm_n, out_inst_n;
  logic [6:0]  opcode_n, funct7_n;
  logic [2:0]  funct3_n, inst_type_n;
  logic [4:0]  rs1_n, rs2_n, rd_n;

  idu_stage #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .inst_type(inst_type), .imm(imm), .illegal(illegal)
  );

  idu_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_pc(out_pc_n), .out_inst(out_inst_n), .opcode(opcode_n), .funct3(funct3_n),
    .funct7(funct7_n), .rs1(rs1_n), .rs2(rs2_n), .rd(rd_n), .inst_type(inst_type_n),
    .imm(imm_n), .illegal(illegal_n)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] seen[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          chk_en = 1'b0;

  logic [6:0] ops [20] = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h27,
                           7'h2F, 7'h33, 7'h3B, 7'h53, 7'h17, 7'h37, 7'h43, 7'h47, 7'h4B,
                           7'h4F, 7'h63};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_type(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    if (inst[1:0] != 2'b11) return 3'd7;
    if (op inside {7'h03, 7'h07, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73}) return 3'd1;
    if (op inside {7'h23, 7'h27}) return 3'd2;
    if (op inside {7'h2F, 7'h33, 7'h3B, 7'h53}) return 3'd0;
    if (op inside {7'h17, 7'h37}) return 3'd4;
    if (op inside {7'h43, 7'h47, 7'h4B, 7'h4F}) return 3'd6;
    if (op == 7'h63) return 3'd3;
    if (op == 7'h6F) return 3'd5;
    return 3'd7;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] inst);
    logic [11:0] f12;
    logic [12:0] f13;
    logic [20:0] f21;
    logic [31:0] f32;
    case (ref_type(inst))
      3'd1: begin f12 = inst[31:20];                   return 64'($signed(f12)); end
      3'd2: begin f12 = {inst[31:25], inst[11:7]};     return 64'($signed(f12)); end
      3'd3: begin
        f13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        return 64'($signed(f13));
      end
      3'd4: begin f32 = {inst[31:12], 12'h000};        return 64'($signed(f32)); end
      3'd5: begin
        f21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        return 64'($signed(f21));
      end
      default: return 64'd0;
    endcase
  endfunction

  ent_t        h;
  logic [63:0] m_imm;
  logic [2:0]  m_type;
  logic        m_rdy, m_acc, m_con;

  always @(negedge clk) begin
    if (chk_en) begin
      m_rdy = !rst && (q.size() < DEPTH);
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
      chk("in_ready32", {63'd0, in_ready_n}, {63'd0, m_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      chk("out_valid32", {63'd0, out_valid_n}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
        h      = q[0];
        m_type = ref_type(h.inst);
        m_imm  = ref_imm(h.inst);
        chk("out_pc", out_pc, h.pc);
        chk("out_inst", {32'd0, out_inst}, {32'd0, h.inst});
        chk("fields", {37'd0, funct7, rs2, rs1, funct3, rd, opcode},
            {37'd0, h.inst[31:25], h.inst[24:20], h.inst[19:15], h.inst[14:12],
             h.inst[11:7], h.inst[6:0]});
        chk("inst_type", {61'd0, inst_type}, {61'd0, m_type});
        chk("imm", imm, m_imm);
        chk("illegal", {63'd0, illegal}, {63'd0, m_type == 3'd7});
        chk("pc32", {32'd0, out_pc_n}, {32'd0, h.pc[31:0]});
        chk("imm32", {32'd0, imm_n}, {32'd0, m_imm[31:0]});
        chk("type32", {61'd0, inst_type_n}, {61'd0, m_type});
      end else begin
        chk("idle_pc", out_pc, 64'd0);
        chk("idle_inst", {32'd0, out_inst}, 64'd0);
        chk("idle_fields", {28'd0, funct7, rs2, rs1, funct3, rd, opcode, inst_type, illegal},
            64'd0);
        chk("idle_imm", imm, 64'd0);
      end
      m_acc = in_valid && m_rdy && !flush;
      m_con = (q.size() != 0) && out_ready && !flush && !rst;
      if (m_con) seen.push_back(out_inst);
      if (rst || flush) begin
        q.delete();
      end else begin
        if (m_con) void'(q.pop_front());
        if (m_acc) q.push_back('{inst: in_inst, pc: in_pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer1(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 19)];
    else if ($urandom_range(0, 1) != 0) r[6:0] = 7'h6F;
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

    out_ready = 1'b1;
    offer1(32'hFFF1_0093, 64'h8000_0000);
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_opcode", {57'd0, opcode}, 64'h13);
    chk("addi_rd", {59'd0, rd}, 64'd1);
    chk("addi_rs1", {59'd0, rs1}, 64'd2);
    chk("addi_type", {61'd0, inst_type}, 64'd1);
    chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_pc", out_pc, 64'h8000_0000);
    tick();
    offer1(32'h8000_02B7, 64'h8000_0004);
    chk("lui_type", {61'd0, inst_type}, 64'd4);
    chk("lui_rd", {59'd0, rd}, 64'd5);
    chk("lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", {32'd0, imm_n}, 64'h8000_0000);
    tick();
    offer1(32'hFFDF_F06F, 64'h8000_0008);
    chk("jal_type", {61'd0, inst_type}, 64'd5);
    chk("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    offer1(32'h0000_0000, 64'h8000_000C);
    chk("zero_illegal", {63'd0, illegal}, 64'd1);
    chk("zero_type", {61'd0, inst_type}, 64'd7);
    chk("zero_imm", imm, 64'd0);
    tick();
    offer1(32'h0000_005B, 64'h8000_0010);
    chk("5b_illegal", {63'd0, illegal}, 64'd1);
    chk("5b_type", {61'd0, inst_type}, 64'd7);
    tick();

    // Backpressure: A and B fill the buffer, C is held until space frees.
    out_ready = 1'b0;
    seen.delete();
    in_valid = 1'b1; in_pc = 64'h100;
    in_inst = 32'h00A0_0093; tick();
    in_inst = 32'h00B1_0113; tick();
    in_inst = 32'h00C1_8193; tick();
    chk("full_ready", {63'd0, in_ready}, 64'd0);
    chk("full_head", {32'd0, out_inst}, 64'h00A0_0093);
    tick();
    chk("held_head", {32'd0, out_inst}, 64'h00A0_0093);
    out_ready = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("order_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("order_a", {32'd0, seen[0]}, 64'h00A0_0093);
      chk("order_b", {32'd0, seen[1]}, 64'h00B1_0113);
      chk("order_c", {32'd0, seen[2]}, 64'h00C1_8193);
    end

    // Flush with a full buffer and a same-cycle offer.
    out_ready = 1'b0;
    offer1(32'h0011_0113, 64'h200);
    offer1(32'h0021_0113, 64'h204);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0031_0113;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    offer1(32'h0041_0113, 64'h208);
    chk("flush_next_valid", {63'd0, out_valid}, 64'd1);
    chk("flush_next_head", {32'd0, out_inst}, 64'h0041_0113);
    out_ready = 1'b1;
    tick();

    // Reset with one buffered entry while the consumer is ready.
    out_ready = 1'b0;
    offer1(32'h0051_0113, 64'h300);
    out_ready = 1'b1; rst = 1'b1;
    #1;
    chk("rst_hold_ready", {63'd0, in_ready}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_ready_after", {63'd0, in_ready}, 64'd1);

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) == 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      tick();
    end

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
